mc_ctrl_gen2: RTL and testbench

- Second-generation multicycle MIPS control unit.
- Contains an explicit main FSM, an ALU decoder and PC-enable logic.
- Adds to the first generation: variable-latency memory handshake, jal, zero-extended logic immediates, slti, illegal-opcode flagging, corrected bne and a retired-instruction counter.
- Sits between the instruction register (op, funct) and the multicycle datapath; drives every datapath mux and enable.

---
 rtl/mc_ctrl_gen2.sv | 169 ++++++++++++++++
 tb/tb_mc_ctrl_gen2.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_gen2.sv
// mc_ctrl_gen2: multicycle MIPS control FSM with memory handshake, ALU decode, PC enable and retire counter
module mc_ctrl_gen2 #(
  parameter int ALUCTRL_W = 3,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 irwrite,
  output logic                 memwrite,
  output logic                 iord,
  output logic                 pcen,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 extop,
  output logic                 regwrite,
  output logic [1:0]           regdst,
  output logic [1:0]           memtoreg,
  output logic                 illegal_op,
  output logic [3:0]           state_out,
  output logic [CNT_W-1:0]     retired
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
    S_RTWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP, S_JAL
  } state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  logic [2:0] w_alu;
  logic w_rdy, w_irwrite, w_memwrite, w_pcwrite, w_branch, w_regwrite, w_illegal, w_retire;
  assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  always_comb begin
    w_next = r_state;
    w_irwrite = 1'b0;
    w_memwrite = 1'b0;
    w_pcwrite = 1'b0;
    w_branch = 1'b0;
    w_regwrite = 1'b0;
    w_illegal = 1'b0;
    w_alu = 3'b010;
    iord = 1'b0;
    pcsrc = 2'b00;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    extop = 1'b1;
    regdst = 2'b00;
    memtoreg = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        w_irwrite = w_rdy;
        w_pcwrite = w_rdy;
        w_next = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000: w_next = S_RTEX;
          6'b000100, 6'b000101: w_next = S_BRANCH;
          6'b001000, 6'b001100, 6'b001101, 6'b001010: w_next = S_IMMEX;
          6'b000010: w_next = S_JUMP;
          6'b000011: w_next = S_JAL;
          default: begin
            w_next = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg = 2'b01;
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        w_memwrite = 1'b1;
        w_next = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        w_next = S_RTWB;
        case (funct)
          6'b100000: w_alu = 3'b010;
          6'b100010: w_alu = 3'b110;
          6'b100100: w_alu = 3'b000;
          6'b100101: w_alu = 3'b001;
          6'b101010: w_alu = 3'b111;
          default: begin
            w_illegal = 1'b1;
            w_next = S_FETCH;
          end
        endcase
      end
      S_RTWB: begin
        w_regwrite = 1'b1;
        regdst = 2'b01;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        w_alu = 3'b110;
        pcsrc = 2'b01;
        w_branch = 1'b1;
        w_next = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_alu = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 :
                (op == 6'b001010) ? 3'b111 : 3'b010;
        extop = !(op == 6'b001100 || op == 6'b001101);
        w_next = S_IMMWB;
      end
      S_IMMWB: begin
        w_regwrite = 1'b1;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        w_pcwrite = 1'b1;
        w_next = S_FETCH;
      end
      S_JAL: begin
        w_regwrite = 1'b1;
        regdst = 2'b10;
        memtoreg = 2'b10;
        pcsrc = 2'b10;
        w_pcwrite = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // Returning to FETCH from anything but FETCH/DECODE/RTEX is a completed instruction
  assign w_retire = (w_next == S_FETCH) && !(r_state inside {S_FETCH, S_DECODE, S_RTEX});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end
  assign irwrite = w_irwrite & !reset;
  assign memwrite = w_memwrite & !reset;
  assign regwrite = w_regwrite & !reset;
  assign illegal_op = w_illegal & !reset;
  assign pcen = !reset & (w_pcwrite | (w_branch & (zero ^ (op == 6'b000101))));
  assign alucontrol = ALUCTRL_W'(w_alu);
  assign state_out = r_state;
  assign retired = r_retired;
endmodule

// File: tb/tb_mc_ctrl_gen2.sv
// tb_mc_ctrl_gen2: per-instruction state-path model with a per-cycle output compare
module tb_mc_ctrl_gen2;
  localparam int CW = 2;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
    BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010,
    JOP = 6'b000010, JALOP = 6'b000011;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic irwrite, memwrite, iord, pcen, alusrca, extop, regwrite, illegal_op;
  logic [1:0] pcsrc, alusrcb, regdst, memtoreg;
  logic [2:0] alucontrol;
  logic [3:0] state_out;
  logic [CW-1:0] retired;
  mc_ctrl_gen2 #(.ALUCTRL_W(3), .MEM_WAIT_EN(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .irwrite(irwrite), .memwrite(memwrite), .iord(iord), .pcen(pcen), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .extop(extop),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .illegal_op(illegal_op),
    .state_out(state_out), .retired(retired)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic irw, mw, iord, pcen;
    logic [1:0] pcsrc;
    logic [2:0] alu;
    logic asa;
    logic [1:0] asb;
    logic ext, rw;
    logic [1:0] rdst, m2r;
    logic ill;
    logic [3:0] st;
  } outs_t;
  outs_t exp_v, dut_v, o;
  assign dut_v = {irwrite, memwrite, iord, pcen, pcsrc, alucontrol, alusrca, alusrcb, extop,
                  regwrite, regdst, memtoreg, illegal_op, state_out};
  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;
  logic [CW-1:0] m_ret = '0;
  int m_sq[$];
  logic m_rq[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask
  function automatic outs_t exp_outs(input int s, input logic [5:0] op_i, input logic [5:0] f,
                                     input logic z, input logic rdy, input logic rs);
    outs_t e;
    e = '0;
    e.alu = 3'b010;
    e.ext = 1'b1;
    e.st = 4'(s);
    case (s)
      0: begin e.asb = 2'b01; e.irw = rdy; e.pcen = rdy; end
      1: begin
        e.asb = 2'b11;
        e.ill = !(op_i inside {LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, SLTI, JOP, JALOP});
      end
      2: begin e.asa = 1'b1; e.asb = 2'b10; end
      3: e.iord = 1'b1;
      4: begin e.rw = 1'b1; e.m2r = 2'b01; end
      5: begin e.iord = 1'b1; e.mw = 1'b1; end
      6: begin
        e.asa = 1'b1;
        e.alu = f == 6'h22 ? 3'b110 : f == 6'h24 ? 3'b000 : f == 6'h25 ? 3'b001 :
                f == 6'h2a ? 3'b111 : 3'b010;
        e.ill = !(f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
      end
      7: begin e.rw = 1'b1; e.rdst = 2'b01; end
      8: begin e.asa = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = z ^ (op_i == BNE); end
      9: begin
        e.asa = 1'b1;
        e.asb = 2'b10;
        e.alu = op_i == ANDI ? 3'b000 : op_i == ORI ? 3'b001 : op_i == SLTI ? 3'b111 : 3'b010;
        e.ext = !(op_i == ANDI || op_i == ORI);
      end
      10: e.rw = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      12: begin e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10; e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    if (rs) begin e.irw = 0; e.mw = 0; e.pcen = 0; e.rw = 0; e.ill = 0; end
    return e;
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk($sformatf("outs_st%0d", exp_v.st), 32'(dut_v), 32'(exp_v));
    chk("retired", 32'(retired), 32'(m_ret));
  end
  task automatic push(input int s, input logic r);
    m_sq.push_back(s);
    m_rq.push_back(r);
  endtask
  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic run_instr(input logic [5:0] o_i, input logic [5:0] f, input logic z,
                           input int fw, input int mw, input int stop);
    bit legal;
    legal = 1;
    m_sq.delete();
    m_rq.delete();
    repeat (fw) push(0, 1'b0);
    push(0, 1'b1);
    push(1, dc());
    case (o_i)
      LW: begin push(2, dc()); repeat (mw) push(3, 1'b0); push(3, 1'b1); push(4, dc()); end
      SW: begin push(2, dc()); repeat (mw) push(5, 1'b0); push(5, 1'b1); end
      RT: begin
        push(6, dc());
        if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) push(7, dc());
        else legal = 0;
      end
      BEQ, BNE: push(8, dc());
      ADDI, ANDI, ORI, SLTI: begin push(9, dc()); push(10, dc()); end
      JOP: push(11, dc());
      JALOP: push(12, dc());
      default: legal = 0;
    endcase
    for (int i = 0; i < m_sq.size() && (stop == 0 || i < stop); i++) begin
      mem_ready = m_rq[i];
      op = o_i;
      funct = f;
      zero = z;
      exp_v = exp_outs(m_sq[i], o_i, f, z, m_rq[i], 1'b0);
      chk_en = 1'b1;
      @(posedge clk);
      #2;
    end
    if (legal && stop == 0) m_ret = m_ret + 1'b1;
  endtask
  initial begin
    o = exp_outs(4, LW, 6'h0, 1'b0, 1'b1, 1'b0);
    chk("pin_lw_wb_rw", 32'(o.rw), 32'd1);
    chk("pin_lw_wb_m2r", 32'(o.m2r), 32'd1);
    o = exp_outs(8, BNE, 6'h0, 1'b1, 1'b1, 1'b0);
    chk("pin_bne_z1", 32'(o.pcen), 32'd0);
    o = exp_outs(8, BNE, 6'h0, 1'b0, 1'b1, 1'b0);
    chk("pin_bne_z0", 32'(o.pcen), 32'd1);
    o = exp_outs(9, ORI, 6'h0, 1'b0, 1'b1, 1'b0);
    chk("pin_ori", 32'({o.alu, o.ext}), 32'b0010);
    o = exp_outs(9, SLTI, 6'h0, 1'b0, 1'b1, 1'b0);
    chk("pin_slti", 32'({o.alu, o.ext}), 32'b1111);
    o = exp_outs(12, JALOP, 6'h0, 1'b0, 1'b1, 1'b0);
    chk("pin_jal", 32'({o.rdst, o.m2r, o.pcsrc, o.pcen}), 32'b1010101);
    o = exp_outs(1, 6'h3f, 6'h0, 1'b0, 1'b1, 1'b0);
    chk("pin_illegal", 32'(o.ill), 32'd1);
    o = exp_outs(0, LW, 6'h0, 1'b0, 1'b0, 1'b0);
    chk("pin_fetch_wait", 32'({o.irw, o.pcen}), 32'd0);
    exp_v = exp_outs(0, 6'h0, 6'h0, 1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    run_instr(LW, 6'h0, 1'b0, 0, 0, 0);
    run_instr(BEQ, 6'h0, 1'b1, 0, 0, 0);
    run_instr(BNE, 6'h0, 1'b1, 0, 0, 0);
    run_instr(BNE, 6'h0, 1'b0, 0, 0, 0);
    run_instr(BEQ, 6'h0, 1'b0, 0, 0, 0);
    run_instr(ADDI, 6'h0, 1'b0, 3, 0, 0);
    run_instr(SW, 6'h0, 1'b0, 0, 2, 0);
    run_instr(LW, 6'h0, 1'b1, 1, 3, 0);
    run_instr(ORI, 6'h0, 1'b0, 0, 0, 0);
    run_instr(ANDI, 6'h0, 1'b0, 0, 0, 0);
    run_instr(SLTI, 6'h0, 1'b0, 0, 0, 0);
    run_instr(JALOP, 6'h0, 1'b0, 0, 0, 0);
    run_instr(JOP, 6'h0, 1'b0, 2, 0, 0);
    run_instr(6'b111111, 6'h0, 1'b0, 0, 0, 0);
    run_instr(RT, 6'b001000, 1'b0, 0, 0, 0);
    run_instr(RT, 6'h20, 1'b0, 0, 0, 0);
    run_instr(RT, 6'h22, 1'b1, 0, 0, 0);
    run_instr(RT, 6'h24, 1'b0, 0, 0, 0);
    run_instr(RT, 6'h25, 1'b0, 0, 0, 0);
    run_instr(RT, 6'h2a, 1'b0, 0, 0, 0);
    run_instr(SW, 6'h0, 1'b0, 0, 3, 4);
    chk_en = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("mw_before_reset", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("mw_async_drop", 32'(memwrite), 32'd0);
    chk("state_in_reset", 32'(state_out), 32'd0);
    chk("retired_in_reset", 32'(retired), 32'd0);
    m_ret = '0;
    exp_v = exp_outs(0, SW, 6'h0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    run_instr(JOP, 6'h0, 1'b0, 0, 0, 0);
    run_instr(JALOP, 6'h0, 1'b0, 0, 0, 0);
    run_instr(BEQ, 6'h0, 1'b1, 0, 0, 0);
    chk("retired_three", 32'(retired), 32'd3);
    run_instr(IMMWB_OP(), 6'h0, 1'b0, 0, 0, 0);
    chk("retired_wrap", 32'(retired), 32'd0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  function automatic logic [5:0] IMMWB_OP();
    return ADDI;
  endfunction
endmodule
